// File: rtl/rob_retire_if.sv
// Dispatch-side bundle for the reorder buffer: allocation, completion
// result buses, retire outputs and occupancy status.
interface rob_retire_if #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 7,
  parameter int DATA_W = 32
);
  localparam int RW = $clog2(DEPTH);

  // allocation, two slots, slot 0 is older
  logic [1:0]             i_alloc_valid;
  logic [1:0][PREG_W-1:0] i_alloc_dst;
  logic [1:0][PREG_W-1:0] i_alloc_old_dst;
  logic [1:0]             i_alloc_regwrite;
  logic [1:0]             i_alloc_memwrite;
  logic                   o_alloc_ready;
  logic [RW-1:0]          o_tail;

  // completion, one bus per functional unit
  logic [2:0]             i_cmpl_valid;
  logic [2:0][RW-1:0]     i_cmpl_rob;
  logic [2:0][DATA_W-1:0] i_cmpl_data;

  // retire, two slots, slot 0 is older
  logic [1:0]             o_ret_valid;
  logic [1:0][PREG_W-1:0] o_ret_dst;
  logic [1:0][PREG_W-1:0] o_ret_old_dst;
  logic [1:0][DATA_W-1:0] o_ret_data;
  logic [1:0]             o_ret_regwrite;
  logic [1:0]             o_ret_memwrite;

  // occupancy
  logic [RW:0]            o_count;
  logic                   o_empty;
  logic                   o_full;
  logic                   o_overflow;

  // dispatch / result side
  modport master (
    output i_alloc_valid, i_alloc_dst, i_alloc_old_dst, i_alloc_regwrite, i_alloc_memwrite,
    output i_cmpl_valid, i_cmpl_rob, i_cmpl_data,
    input  o_alloc_ready, o_tail,
    input  o_ret_valid, o_ret_dst, o_ret_old_dst, o_ret_data, o_ret_regwrite, o_ret_memwrite,
    input  o_count, o_empty, o_full, o_overflow
  );

  // reorder buffer side
  modport slave (
    input  i_alloc_valid, i_alloc_dst, i_alloc_old_dst, i_alloc_regwrite, i_alloc_memwrite,
    input  i_cmpl_valid, i_cmpl_rob, i_cmpl_data,
    output o_alloc_ready, o_tail,
    output o_ret_valid, o_ret_dst, o_ret_old_dst, o_ret_data, o_ret_regwrite, o_ret_memwrite,
    output o_count, o_empty, o_full, o_overflow
  );
endinterface

// File: rtl/rob_retire.sv
// Reorder buffer: dual in-order allocation, three completion buses,
// dual strictly in-order retire with registered retire outputs.
module rob_retire #(
  parameter int DEPTH  = 16,
  parameter int PREG_W = 7,
  parameter int DATA_W = 32
) (
  input logic         i_clk,
  input logic         i_rst,
  rob_retire_if.slave bus
);
  localparam int RW = $clog2(DEPTH);

  logic [DEPTH-1:0]  ent_valid;
  logic [DEPTH-1:0]  ent_cmpl;
  logic [DEPTH-1:0]  ent_regwrite;
  logic [DEPTH-1:0]  ent_memwrite;
  logic [PREG_W-1:0] ent_dst     [DEPTH];
  logic [PREG_W-1:0] ent_old_dst [DEPTH];
  logic [DATA_W-1:0] ent_data    [DEPTH];

  logic [RW-1:0] head;
  logic [RW-1:0] tail;
  logic [RW:0]   count;
  logic          overflow;

  logic [1:0]             ret_valid;
  logic [1:0][PREG_W-1:0] ret_dst;
  logic [1:0][PREG_W-1:0] ret_old_dst;
  logic [1:0][DATA_W-1:0] ret_data;
  logic [1:0]             ret_regwrite;
  logic [1:0]             ret_memwrite;

  logic [RW-1:0] head_next1;
  logic [RW-1:0] slot1_idx;
  logic          ret0;
  logic          ret1;
  logic          alloc_ready;
  logic [1:0]    n_alloc;
  logic [1:0]    n_ret;

  // retire decisions look only at registered entry state, so a completion
  // arriving this cycle cannot retire before the next edge
  assign head_next1  = head + RW'(1);
  assign ret0        = ent_valid[head] & ent_cmpl[head];
  assign ret1        = ret0 & ent_valid[head_next1] & ent_cmpl[head_next1];
  assign n_ret       = 2'(ret0) + 2'(ret1);

  // a request is all-or-nothing: if two free entries are not guaranteed it is dropped
  assign alloc_ready = (count <= (RW+1)'(DEPTH - 2));
  assign n_alloc     = alloc_ready ? (2'(bus.i_alloc_valid[0]) + 2'(bus.i_alloc_valid[1])) : 2'd0;
  assign slot1_idx   = tail + RW'(bus.i_alloc_valid[0]);

  // entry storage: completions, then retire clears, then new allocations
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ent_valid    <= '0;
      ent_cmpl     <= '0;
      ent_regwrite <= '0;
      ent_memwrite <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_dst[i]     <= '0;
        ent_old_dst[i] <= '0;
        ent_data[i]    <= '0;
      end
    end else begin
      for (int f = 2; f >= 0; f--) begin
        if (bus.i_cmpl_valid[f] && ent_valid[bus.i_cmpl_rob[f]]) begin
          ent_cmpl[bus.i_cmpl_rob[f]] <= 1'b1;
          ent_data[bus.i_cmpl_rob[f]] <= bus.i_cmpl_data[f];
        end
      end
      if (ret0) begin
        ent_valid[head] <= 1'b0;
        ent_cmpl[head]  <= 1'b0;
      end
      if (ret1) begin
        ent_valid[head_next1] <= 1'b0;
        ent_cmpl[head_next1]  <= 1'b0;
      end
      if (alloc_ready && bus.i_alloc_valid[0]) begin
        ent_valid[tail]    <= 1'b1;
        ent_cmpl[tail]     <= 1'b0;
        ent_data[tail]     <= '0;
        ent_dst[tail]      <= bus.i_alloc_dst[0];
        ent_old_dst[tail]  <= bus.i_alloc_old_dst[0];
        ent_regwrite[tail] <= bus.i_alloc_regwrite[0];
        ent_memwrite[tail] <= bus.i_alloc_memwrite[0];
      end
      if (alloc_ready && bus.i_alloc_valid[1]) begin
        ent_valid[slot1_idx]    <= 1'b1;
        ent_cmpl[slot1_idx]     <= 1'b0;
        ent_data[slot1_idx]     <= '0;
        ent_dst[slot1_idx]      <= bus.i_alloc_dst[1];
        ent_old_dst[slot1_idx]  <= bus.i_alloc_old_dst[1];
        ent_regwrite[slot1_idx] <= bus.i_alloc_regwrite[1];
        ent_memwrite[slot1_idx] <= bus.i_alloc_memwrite[1];
      end
    end
  end

  // pointers, occupancy and the sticky dropped-allocation flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      head     <= '0;
      tail     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      head  <= head + RW'(n_ret);
      tail  <= tail + RW'(n_alloc);
      count <= count + (RW+1)'(n_alloc) - (RW+1)'(n_ret);
      if (!alloc_ready && (|bus.i_alloc_valid)) begin
        overflow <= 1'b1;
      end
    end
  end

  // registered retire rows; a slot that does not retire shows all zeros
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      ret_valid    <= '0;
      ret_dst      <= '0;
      ret_old_dst  <= '0;
      ret_data     <= '0;
      ret_regwrite <= '0;
      ret_memwrite <= '0;
    end else begin
      ret_valid       <= {ret1, ret0};
      ret_dst[0]      <= ret0 ? ent_dst[head]      : '0;
      ret_old_dst[0]  <= ret0 ? ent_old_dst[head]  : '0;
      ret_data[0]     <= ret0 ? ent_data[head]     : '0;
      ret_regwrite[0] <= ret0 & ent_regwrite[head];
      ret_memwrite[0] <= ret0 & ent_memwrite[head];
      ret_dst[1]      <= ret1 ? ent_dst[head_next1]     : '0;
      ret_old_dst[1]  <= ret1 ? ent_old_dst[head_next1] : '0;
      ret_data[1]     <= ret1 ? ent_data[head_next1]    : '0;
      ret_regwrite[1] <= ret1 & ent_regwrite[head_next1];
      ret_memwrite[1] <= ret1 & ent_memwrite[head_next1];
    end
  end

  assign bus.o_alloc_ready  = alloc_ready;
  assign bus.o_tail         = tail;
  assign bus.o_count        = count;
  assign bus.o_empty        = (count == '0);
  assign bus.o_full         = (count == (RW+1)'(DEPTH));
  assign bus.o_overflow     = overflow;
  assign bus.o_ret_valid    = ret_valid;
  assign bus.o_ret_dst      = ret_dst;
  assign bus.o_ret_old_dst  = ret_old_dst;
  assign bus.o_ret_data     = ret_data;
  assign bus.o_ret_regwrite = ret_regwrite;
  assign bus.o_ret_memwrite = ret_memwrite;
endmodule

// File: tb/tb_rob_retire.sv
// Directed bench for rob_retire: rows are pushed to an expected queue as
// they are allocated and popped as the reorder buffer retires them.
module tb_rob_retire;
  localparam int DEPTH  = 16;
  localparam int PREG_W = 7;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [PREG_W-1:0] dst;
    logic [PREG_W-1:0] old_dst;
    logic [DATA_W-1:0] data;
    logic              rw;
    logic              mw;
  } exp_t;

  logic i_clk = 1'b0;
  logic i_rst;
  exp_t exp_q[$];
  int   passCount = 0;
  int   failCount = 0;
  int   checkCount = 0;

  rob_retire_if #(.DEPTH(DEPTH), .PREG_W(PREG_W), .DATA_W(DATA_W)) rob_if ();

  rob_retire #(.DEPTH(DEPTH), .PREG_W(PREG_W), .DATA_W(DATA_W)) dut (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .bus   (rob_if)
  );

  // free-running clock, rising edges at 5, 15, 25, ...
  always #5 i_clk = ~i_clk;

  // one comparison: counted, and reported with tag/observed/expected on failure
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    assert (obs === exp) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // each program-order id maps to a distinctive row
  function automatic exp_t row_for(input int id);
    exp_t r;
    r.dst     = PREG_W'(id + 20);
    r.old_dst = PREG_W'(id);
    r.data    = 32'h1000 + DATA_W'(id);
    r.rw      = id[0];
    r.mw      = id[1];
    return r;
  endfunction

  task automatic clearInputs();
    rob_if.i_alloc_valid    = '0;
    rob_if.i_alloc_dst      = '0;
    rob_if.i_alloc_old_dst  = '0;
    rob_if.i_alloc_regwrite = '0;
    rob_if.i_alloc_memwrite = '0;
    rob_if.i_cmpl_valid     = '0;
    rob_if.i_cmpl_rob       = '0;
    rob_if.i_cmpl_data      = '0;
  endtask

  // hold the staged inputs across one rising edge, then release them
  task automatic applyStimulus();
    @(posedge i_clk);
    #1;
    clearInputs();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus();
  endtask

  task automatic setAlloc(input int slot, input int id, input bit accept);
    exp_t r;
    r = row_for(id);
    rob_if.i_alloc_valid[slot]    = 1'b1;
    rob_if.i_alloc_dst[slot]      = r.dst;
    rob_if.i_alloc_old_dst[slot]  = r.old_dst;
    rob_if.i_alloc_regwrite[slot] = r.rw;
    rob_if.i_alloc_memwrite[slot] = r.mw;
    if (accept) exp_q.push_back(r);
  endtask

  task automatic setCmpl(input int fu, input int rob, input logic [DATA_W-1:0] data);
    rob_if.i_cmpl_valid[fu] = 1'b1;
    rob_if.i_cmpl_rob[fu]   = 4'(rob);
    rob_if.i_cmpl_data[fu]  = data;
  endtask

  task automatic allocRun(input int first_id, input int n);
    for (int k = 0; k < n; k += 2) begin
      setAlloc(0, first_id + k, 1'b1);
      if (k + 1 < n) setAlloc(1, first_id + k + 1, 1'b1);
      applyStimulus();
    end
  endtask

  task automatic completeRun(input int first_rob, input int first_id, input int n);
    for (int k = 0; k < n; k += 3) begin
      for (int f = 0; f < 3 && k + f < n; f++) begin
        setCmpl(f, (first_rob + k + f) % DEPTH, row_for(first_id + k + f).data);
      end
      applyStimulus();
    end
  endtask

  task automatic doReset();
    i_rst = 1'b1;
    exp_q.delete();
    #2;
    i_rst = 1'b0;
  endtask

  // scoreboard: every retired slot must match the oldest expected row,
  // and every idle slot must show zeros
  always @(negedge i_clk) begin : monitor
    exp_t e;
    if (!i_rst) begin
      for (int k = 0; k < 2; k++) begin
        if (rob_if.o_ret_valid[k]) begin
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_retire", 64'(1), 64'(0));
          end else begin
            e = exp_q.pop_front();
            checkOutput("ret_dst",      64'(rob_if.o_ret_dst[k]),      64'(e.dst));
            checkOutput("ret_old_dst",  64'(rob_if.o_ret_old_dst[k]),  64'(e.old_dst));
            checkOutput("ret_data",     64'(rob_if.o_ret_data[k]),     64'(e.data));
            checkOutput("ret_regwrite", 64'(rob_if.o_ret_regwrite[k]), 64'(e.rw));
            checkOutput("ret_memwrite", 64'(rob_if.o_ret_memwrite[k]), 64'(e.mw));
          end
        end else begin
          checkOutput("idle_slot_zero",
                      64'({rob_if.o_ret_dst[k], rob_if.o_ret_old_dst[k], rob_if.o_ret_data[k],
                           rob_if.o_ret_regwrite[k], rob_if.o_ret_memwrite[k]}), 64'(0));
        end
      end
    end
  end

  // hard time limit so the run always ends
  initial begin
    #100000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] time limit reached");
  end

  // directed sequence
  initial begin
    exp_t e;
    clearInputs();
    i_rst = 1'b1;
    #12;
    checkOutput("rst_count",    64'(rob_if.o_count),       64'(0));
    checkOutput("rst_empty",    64'(rob_if.o_empty),       64'(1));
    checkOutput("rst_full",     64'(rob_if.o_full),        64'(0));
    checkOutput("rst_ready",    64'(rob_if.o_alloc_ready), 64'(1));
    checkOutput("rst_tail",     64'(rob_if.o_tail),        64'(0));
    checkOutput("rst_ret",      64'(rob_if.o_ret_valid),   64'(0));
    checkOutput("rst_overflow", 64'(rob_if.o_overflow),    64'(0));
    i_rst = 1'b0;

    // mid-stream asynchronous reset
    $display("[TB] mid-stream reset");
    allocRun(50, 5);
    checkOutput("mid_count5", 64'(rob_if.o_count), 64'(5));
    completeRun(0, 50, 2);
    applyStimulus();
    checkOutput("mid_ret_before", 64'(rob_if.o_ret_valid), 64'(3));
    checkOutput("mid_count3",     64'(rob_if.o_count),     64'(3));
    @(negedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    checkOutput("mid_rst_count", 64'(rob_if.o_count),     64'(0));
    checkOutput("mid_rst_ret",   64'(rob_if.o_ret_valid), 64'(0));
    checkOutput("mid_rst_dst",   64'(rob_if.o_ret_dst),   64'(0));
    checkOutput("mid_rst_tail",  64'(rob_if.o_tail),      64'(0));
    checkOutput("mid_rst_empty", 64'(rob_if.o_empty),     64'(1));
    exp_q.delete();
    #5;
    i_rst = 1'b0;

    // basic in-order retire with out-of-order completion
    $display("[TB] basic in-order retire");
    exp_q.push_back('{dst: 7'd10, old_dst: 7'd3, data: 32'hAA, rw: 1'b1, mw: 1'b0});
    exp_q.push_back('{dst: 7'd11, old_dst: 7'd4, data: 32'hBB, rw: 1'b0, mw: 1'b1});
    rob_if.i_alloc_valid    = 2'b11;
    rob_if.i_alloc_dst[0]   = 7'd10;
    rob_if.i_alloc_old_dst[0] = 7'd3;
    rob_if.i_alloc_regwrite[0] = 1'b1;
    rob_if.i_alloc_dst[1]   = 7'd11;
    rob_if.i_alloc_old_dst[1] = 7'd4;
    rob_if.i_alloc_memwrite[1] = 1'b1;
    applyStimulus();
    checkOutput("basic_count", 64'(rob_if.o_count), 64'(2));
    checkOutput("basic_tail",  64'(rob_if.o_tail),  64'(2));
    setCmpl(0, 1, 32'hBB);
    applyStimulus();
    checkOutput("basic_young_blocked", 64'(rob_if.o_ret_valid), 64'(0));
    setCmpl(0, 0, 32'hAA);
    applyStimulus();
    checkOutput("basic_no_bypass", 64'(rob_if.o_ret_valid), 64'(0));
    applyStimulus();
    checkOutput("basic_ret_both", 64'(rob_if.o_ret_valid), 64'(3));
    checkOutput("basic_empty",    64'(rob_if.o_empty),     64'(1));
    applyStimulus();
    checkOutput("basic_ret_idle", 64'(rob_if.o_ret_valid), 64'(0));
    checkOutput("basic_drained",  64'(exp_q.size()),       64'(0));

    // completion to an unallocated entry is ignored
    $display("[TB] stale completion");
    doReset();
    setCmpl(0, 9, 32'hDEAD);
    applyStimulus();
    checkOutput("stale_count", 64'(rob_if.o_count), 64'(0));
    checkOutput("stale_empty", 64'(rob_if.o_empty), 64'(1));
    allocRun(0, 10);
    checkOutput("stale_count10", 64'(rob_if.o_count), 64'(10));
    checkOutput("stale_tail10",  64'(rob_if.o_tail),  64'(10));
    completeRun(0, 0, 9);
    idle(8);
    checkOutput("stale_rob9_blocked", 64'(rob_if.o_count),     64'(1));
    checkOutput("stale_rob9_noret",   64'(rob_if.o_ret_valid), 64'(0));
    completeRun(9, 9, 1);
    applyStimulus();
    checkOutput("stale_rob9_ret",   64'(rob_if.o_ret_valid), 64'(1));
    checkOutput("stale_rob9_count", 64'(rob_if.o_count),     64'(0));
    applyStimulus();
    checkOutput("stale_drained", 64'(exp_q.size()), 64'(0));

    // fill to capacity, then a dropped request
    $display("[TB] fill and overflow");
    doReset();
    allocRun(0, 14);
    checkOutput("fill_count14", 64'(rob_if.o_count),       64'(14));
    checkOutput("fill_ready14", 64'(rob_if.o_alloc_ready), 64'(1));
    checkOutput("fill_full14",  64'(rob_if.o_full),        64'(0));
    allocRun(14, 2);
    checkOutput("fill_count16", 64'(rob_if.o_count),       64'(16));
    checkOutput("fill_full16",  64'(rob_if.o_full),        64'(1));
    checkOutput("fill_ready16", 64'(rob_if.o_alloc_ready), 64'(0));
    checkOutput("fill_no_ovf",  64'(rob_if.o_overflow),    64'(0));
    setAlloc(0, 90, 1'b0);
    setAlloc(1, 91, 1'b0);
    applyStimulus();
    checkOutput("ovf_flag",  64'(rob_if.o_overflow), 64'(1));
    checkOutput("ovf_tail",  64'(rob_if.o_tail),     64'(0));
    checkOutput("ovf_count", 64'(rob_if.o_count),    64'(16));
    completeRun(0, 0, 16);
    idle(10);
    checkOutput("fill_drain_count", 64'(rob_if.o_count),    64'(0));
    checkOutput("fill_drained",     64'(exp_q.size()),      64'(0));
    checkOutput("ovf_sticky",       64'(rob_if.o_overflow), 64'(1));

    // pointer wrap from 15 to 0
    $display("[TB] wrap");
    doReset();
    allocRun(100, 15);
    completeRun(0, 100, 15);
    idle(10);
    checkOutput("wrap_tail15",  64'(rob_if.o_tail),  64'(15));
    checkOutput("wrap_empty",   64'(rob_if.o_empty), 64'(1));
    checkOutput("wrap_drained", 64'(exp_q.size()),   64'(0));
    allocRun(200, 2);
    checkOutput("wrap_tail1",  64'(rob_if.o_tail),  64'(1));
    checkOutput("wrap_count2", 64'(rob_if.o_count), 64'(2));
    completeRun(15, 200, 2);
    applyStimulus();
    checkOutput("wrap_ret_both", 64'(rob_if.o_ret_valid), 64'(3));
    checkOutput("wrap_count0",   64'(rob_if.o_count),     64'(0));
    applyStimulus();
    checkOutput("wrap_drained2", 64'(exp_q.size()), 64'(0));

    // allocate, complete and retire in the same cycle
    $display("[TB] simultaneous events");
    doReset();
    allocRun(300, 14);
    e = exp_q[5];
    e.data = 32'h11;
    exp_q[5] = e;
    completeRun(0, 300, 2);
    checkOutput("sim_count14_pre", 64'(rob_if.o_count), 64'(14));
    setAlloc(0, 314, 1'b1);
    setAlloc(1, 315, 1'b1);
    setCmpl(0, 5, 32'h11);
    setCmpl(1, 2, row_for(302).data);
    setCmpl(2, 5, 32'h22);
    applyStimulus();
    checkOutput("sim_count14", 64'(rob_if.o_count),     64'(14));
    checkOutput("sim_tail0",   64'(rob_if.o_tail),      64'(0));
    checkOutput("sim_ret",     64'(rob_if.o_ret_valid), 64'(3));
    completeRun(3, 303, 2);
    completeRun(6, 306, 10);
    idle(10);
    checkOutput("sim_count0", 64'(rob_if.o_count), 64'(0));
    checkOutput("sim_drained", 64'(exp_q.size()),  64'(0));

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
